// File: rtl/fft32_pkg.sv
// Shared definitions for the 32-point FFT datapath: frame geometry,
// collector state encoding and the default sample type.
package fft32_pkg;

   localparam int N_POINTS          = 32;
   localparam int IDX_W             = 5;
   localparam int IN_ELEMENT_LENGTH = 8;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } collector_state_t;

   typedef logic signed [IN_ELEMENT_LENGTH-1:0] sample_t;

   // True when the write index points at the last slot of a frame.
   function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
      return idx == IDX_W'(N_POINTS - 1);
   endfunction

endpackage

// File: rtl/fft_sample_collector.sv
// Serial-to-parallel front end of the 32-point FFT: gathers samples
// into a shadow buffer and hands each complete frame to a held output
// bank with a one-cycle EN strobe. While the FFT core is busy with a
// completed frame, the collector parks in HOLD and back-pressures.
module fft_sample_collector
   import fft32_pkg::*;
#(
   parameter int IN_ELEMENT_LENGTH = 8
) (
   input  logic                                clk2,
   input  logic                                rst_n,
   input  logic signed [IN_ELEMENT_LENGTH-1:0] sample_in,
   input  logic                                sample_valid,
   output logic                                sample_ready,
   input  logic                                frame_sync,
   input  logic                                fft_ready,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_0,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_1,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_2,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_3,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_4,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_5,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_6,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_7,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_8,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_9,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_10,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_11,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_12,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_13,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_14,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_15,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_16,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_17,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_18,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_19,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_20,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_21,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_22,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_23,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_24,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_25,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_26,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_27,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_28,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_29,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_30,
   output logic signed [IN_ELEMENT_LENGTH-1:0] out_31,
   output logic                                EN,
   output logic                                sync_err
);

   collector_state_t                    state_q;
   logic [IDX_W-1:0]                    wr_idx_q;
   logic signed [IN_ELEMENT_LENGTH-1:0] shadow_q [N_POINTS];
   logic signed [IN_ELEMENT_LENGTH-1:0] bank_q   [N_POINTS];
   logic signed [IN_ELEMENT_LENGTH-1:0] frame_d  [N_POINTS];
   logic                                en_q;
   logic                                sync_err_q;

   logic                                xfer;
   logic [IDX_W-1:0]                    wr_ptr;

   // Ready depends on state alone so the source never sees a loop
   // through sample_valid or fft_ready.
   assign sample_ready = (state_q == FILL);
   assign xfer         = sample_valid && sample_ready;

   // A frame_sync sample always lands in slot 0, restarting the frame.
   assign wr_ptr = frame_sync ? '0 : wr_idx_q;

   // Frame image presented to the output bank: in FILL the last sample
   // bypasses the shadow so the bank updates on the accepting edge; in
   // HOLD the last sample was already parked in shadow slot 31.
   always_comb begin
      for (int k = 0; k < N_POINTS; k++) begin
         frame_d[k] = shadow_q[k];
      end
      if (state_q == FILL) begin
         frame_d[N_POINTS-1] = sample_in;
      end
   end

   // Shadow buffer: plain storage, one indexed write per accepted sample.
   // Not reset: stale content is unreachable once wr_idx returns to 0.
   always_ff @(posedge clk2) begin
      if (xfer) begin
         shadow_q[wr_ptr] <= sample_in;
      end
   end

   // Collector FSM with registered bank, EN and sync_err.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FILL;
         wr_idx_q   <= '0;
         en_q       <= 1'b0;
         sync_err_q <= 1'b0;
         for (int k = 0; k < N_POINTS; k++) begin
            bank_q[k] <= '0;
         end
      end else begin
         en_q       <= 1'b0;
         sync_err_q <= 1'b0;
         case (state_q)
            FILL: begin
               if (xfer) begin
                  if (frame_sync) begin
                     // Restart; anything already collected is dropped.
                     wr_idx_q   <= IDX_W'(1);
                     sync_err_q <= (wr_idx_q != '0);
                  end else if (is_last_idx(wr_idx_q)) begin
                     if (fft_ready) begin
                        bank_q   <= frame_d;
                        en_q     <= 1'b1;
                        wr_idx_q <= '0;
                     end else begin
                        state_q  <= HOLD;
                     end
                  end else begin
                     wr_idx_q <= wr_idx_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (fft_ready) begin
                  bank_q   <= frame_d;
                  en_q     <= 1'b1;
                  wr_idx_q <= '0;
                  state_q  <= FILL;
               end
            end
            default: begin
               state_q <= FILL;
            end
         endcase
      end
   end

   assign EN       = en_q;
   assign sync_err = sync_err_q;

   assign out_0  = bank_q[0];
   assign out_1  = bank_q[1];
   assign out_2  = bank_q[2];
   assign out_3  = bank_q[3];
   assign out_4  = bank_q[4];
   assign out_5  = bank_q[5];
   assign out_6  = bank_q[6];
   assign out_7  = bank_q[7];
   assign out_8  = bank_q[8];
   assign out_9  = bank_q[9];
   assign out_10 = bank_q[10];
   assign out_11 = bank_q[11];
   assign out_12 = bank_q[12];
   assign out_13 = bank_q[13];
   assign out_14 = bank_q[14];
   assign out_15 = bank_q[15];
   assign out_16 = bank_q[16];
   assign out_17 = bank_q[17];
   assign out_18 = bank_q[18];
   assign out_19 = bank_q[19];
   assign out_20 = bank_q[20];
   assign out_21 = bank_q[21];
   assign out_22 = bank_q[22];
   assign out_23 = bank_q[23];
   assign out_24 = bank_q[24];
   assign out_25 = bank_q[25];
   assign out_26 = bank_q[26];
   assign out_27 = bank_q[27];
   assign out_28 = bank_q[28];
   assign out_29 = bank_q[29];
   assign out_30 = bank_q[30];
   assign out_31 = bank_q[31];

endmodule

// File: tb/tb_fft_sample_collector.sv
// Directed and randomized bench for fft_sample_collector, checked every
// cycle against a queue-based frame model.
module tb_fft_sample_collector;

   logic       clk2 = 1'b0;
   logic       rst_n;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       frame_sync;
   logic       fft_ready;
   wire        sample_ready;
   wire        EN;
   wire        sync_err;
   wire [7:0]  out_0,  out_1,  out_2,  out_3,  out_4,  out_5,  out_6,  out_7;
   wire [7:0]  out_8,  out_9,  out_10, out_11, out_12, out_13, out_14, out_15;
   wire [7:0]  out_16, out_17, out_18, out_19, out_20, out_21, out_22, out_23;
   wire [7:0]  out_24, out_25, out_26, out_27, out_28, out_29, out_30, out_31;

   wire [255:0] got_bus = {out_31, out_30, out_29, out_28, out_27, out_26, out_25, out_24,
                           out_23, out_22, out_21, out_20, out_19, out_18, out_17, out_16,
                           out_15, out_14, out_13, out_12, out_11, out_10, out_9,  out_8,
                           out_7,  out_6,  out_5,  out_4,  out_3,  out_2,  out_1,  out_0};

   always #5 clk2 = ~clk2;

   fft_sample_collector #(.IN_ELEMENT_LENGTH(8)) dut (
      .clk2(clk2), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .frame_sync(frame_sync), .fft_ready(fft_ready),
      .out_0(out_0),   .out_1(out_1),   .out_2(out_2),   .out_3(out_3),
      .out_4(out_4),   .out_5(out_5),   .out_6(out_6),   .out_7(out_7),
      .out_8(out_8),   .out_9(out_9),   .out_10(out_10), .out_11(out_11),
      .out_12(out_12), .out_13(out_13), .out_14(out_14), .out_15(out_15),
      .out_16(out_16), .out_17(out_17), .out_18(out_18), .out_19(out_19),
      .out_20(out_20), .out_21(out_21), .out_22(out_22), .out_23(out_23),
      .out_24(out_24), .out_25(out_25), .out_26(out_26), .out_27(out_27),
      .out_28(out_28), .out_29(out_29), .out_30(out_30), .out_31(out_31),
      .EN(EN), .sync_err(sync_err)
   );

   // Reference model: the samples of the frame being built, whether a
   // complete frame is waiting for the FFT, and what the bank should show.
   logic [7:0] part_q [$];
   bit         held;
   logic [7:0] exp_out [32];
   bit         exp_en;
   bit         exp_err;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int en_cnt   = 0;
   int last_en_cyc = 0;
   int en_gap   = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] exp_bus();
      logic [255:0] r;
      for (int k = 0; k < 32; k++) r[k*8 +: 8] = exp_out[k];
      return r;
   endfunction

   task automatic publish();
      for (int k = 0; k < 32; k++) exp_out[k] = part_q[k];
      part_q.delete();
      exp_en = 1'b1;
   endtask

   // One clock cycle: drive at the falling edge, predict, check after the rise.
   task automatic tick(input bit v, input bit s, input logic [7:0] d, input bit f);
      sample_valid = v;
      frame_sync   = s;
      sample_in    = d;
      fft_ready    = f;
      #1;
      chk("sample_ready", 256'(sample_ready), 256'(!held));
      exp_en  = 1'b0;
      exp_err = 1'b0;
      if (!held) begin
         if (v) begin
            if (s) begin
               if (part_q.size() != 0) exp_err = 1'b1;
               part_q.delete();
               part_q.push_back(d);
            end else begin
               part_q.push_back(d);
               if (part_q.size() == 32) begin
                  if (f) publish();
                  else held = 1'b1;
               end
            end
         end
      end else if (f) begin
         publish();
         held = 1'b0;
      end
      @(posedge clk2);
      @(negedge clk2);
      cyc++;
      chk("EN", 256'(EN), 256'(exp_en));
      chk("sync_err", 256'(sync_err), 256'(exp_err));
      chk("out_bank", got_bus, exp_bus());
      if (EN) begin
         en_cnt++;
         en_gap = cyc - last_en_cyc;
         last_en_cyc = cyc;
      end
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      part_q.delete();
      held = 1'b0;
      for (int k = 0; k < 32; k++) exp_out[k] = 8'h00;
      #1;
      chk("rst_out", got_bus, exp_bus());
      chk("rst_EN", 256'(EN), 256'(0));
      chk("rst_sync_err", 256'(sync_err), 256'(0));
      @(negedge clk2);
      rst_n = 1'b1;
   endtask

   task automatic send_frame(input bit rnd);
      for (int k = 0; k < 32; k++) tick(1'b1, k == 0, rnd ? 8'($urandom) : 8'(k * 3), 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int en0;
      int accepted;
      int iter;
      bit alt;
      bit v;
      bit f;
      rst_n        = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      frame_sync   = 1'b0;
      fft_ready    = 1'b0;
      held         = 1'b0;
      for (int k = 0; k < 32; k++) exp_out[k] = 8'h00;
      @(negedge clk2);
      @(negedge clk2);
      chk("init_out", got_bus, exp_bus());
      chk("init_EN", 256'(EN), 256'(0));
      rst_n = 1'b1;

      // Ramp frame k-16 with frame_sync on the first sample.
      en0 = en_cnt;
      for (int k = 0; k < 32; k++) tick(1'b1, k == 0, 8'(k - 16), 1'b1);
      chk("ramp_en_count", 256'(en_cnt - en0), 256'(1));
      for (int k = 0; k < 32; k++) begin
         logic [7:0] want;
         want = 8'(k - 16);
         chk("ramp_out_k", 256'(got_bus[k*8 +: 8]), 256'(want));
      end

      // Two back-to-back frames with no gaps: EN exactly 32 cycles apart.
      en0 = en_cnt;
      send_frame(1'b1);
      send_frame(1'b1);
      chk("b2b_en_count", 256'(en_cnt - en0), 256'(2));
      chk("b2b_en_gap", 256'(en_gap), 256'(32));

      // fft_ready low on sample 31 -> HOLD for 5 cycles, then release.
      en0 = en_cnt;
      for (int k = 0; k < 31; k++) tick(1'b1, k == 0, 8'($urandom), 1'b1);
      tick(1'b1, 1'b0, 8'($urandom), 1'b0);
      for (int k = 0; k < 5; k++) tick(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      chk("hold_no_en", 256'(en_cnt - en0), 256'(0));
      tick(1'b1, 1'b0, 8'($urandom), 1'b1);
      chk("hold_exit_en", 256'(en_cnt - en0), 256'(1));
      tick(1'b0, 1'b0, 8'h00, 1'b0);

      // frame_sync on the 10th sample (0x7F) discards the 9 earlier ones.
      en0 = en_cnt;
      for (int k = 0; k < 9; k++) tick(1'b1, k == 0, 8'($urandom), 1'b1);
      tick(1'b1, 1'b1, 8'h7F, 1'b1);
      for (int k = 0; k < 31; k++) tick(1'b1, 1'b0, 8'($urandom), 1'b1);
      chk("resync_en_count", 256'(en_cnt - en0), 256'(1));
      chk("resync_out_0", 256'(got_bus[7:0]), 256'(8'h7F));

      // frame_sync on the sample-31 slot restarts instead of completing.
      en0 = en_cnt;
      for (int k = 0; k < 31; k++) tick(1'b1, k == 0, 8'($urandom), 1'b1);
      tick(1'b1, 1'b1, 8'h55, 1'b1);
      chk("sync31_no_en", 256'(en_cnt - en0), 256'(0));
      for (int k = 0; k < 31; k++) tick(1'b1, 1'b0, 8'($urandom), 1'b1);
      chk("sync31_en", 256'(en_cnt - en0), 256'(1));

      // Random valid gaps, 0x80/0x7F alternating, random fft_ready.
      en0 = en_cnt;
      accepted = 0;
      iter = 0;
      alt = 1'b0;
      while (accepted < 96 && iter < 3000) begin
         v = bit'($urandom_range(0, 1));
         f = ($urandom_range(0, 3) != 0);
         if (v && !held) begin
            tick(1'b1, 1'b0, alt ? 8'h7F : 8'h80, f);
            alt = ~alt;
            accepted++;
         end else begin
            tick(v, 1'b0, 8'($urandom), f);
         end
         iter++;
      end
      chk("rand_accepted", 256'(accepted), 256'(96));
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 8'h00, 1'b1);
      chk("rand_en_count", 256'(en_cnt - en0), 256'(accepted / 32));

      // Reset after 20 samples, then a clean frame.
      for (int k = 0; k < 20; k++) tick(1'b1, k == 0, 8'($urandom), 1'b1);
      do_reset();
      en0 = en_cnt;
      send_frame(1'b0);
      chk("post_rst_en", 256'(en_cnt - en0), 256'(1));

      // Reset while in HOLD, then a clean frame.
      for (int k = 0; k < 31; k++) tick(1'b1, k == 0, 8'($urandom), 1'b1);
      tick(1'b1, 1'b0, 8'($urandom), 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      do_reset();
      en0 = en_cnt;
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      chk("hold_rst_no_en", 256'(en_cnt - en0), 256'(0));
      send_frame(1'b1);
      chk("post_hold_rst_en", 256'(en_cnt - en0), 256'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_sample_collector.md
# fft_sample_collector

Serial-to-parallel front end of the 32-point FFT datapath. It accepts signed time-domain samples one per cycle over a valid/ready handshake and assembles them in a shadow buffer. It transfers each complete 32-sample frame to a held parallel output bank with a one-cycle frame-valid pulse. It drives the parallel inputs and enable of the FFT input register stage directly, and holds off the sample source while the FFT core cannot take a new frame.

## Interface
- IN_ELEMENT_LENGTH, 8, signed sample width (two's complement).
- clk2  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sample_in  in  IN_ELEMENT_LENGTH  signed input sample.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  collector accepts a sample this cycle; a transfer occurs when sample_valid && sample_ready.
- frame_sync  in  1  qualified by the transfer; marks the accepted sample as index 0 of a new frame.
- fft_ready  in  1  downstream can take a new frame this cycle.
- out_0 … out_31  out  IN_ELEMENT_LENGTH each  parallel frame, out_k = k-th sample of the frame.
- EN  out  1  one-cycle pulse: out_0..out_31 carry a new frame.
- sync_err  out  1  one-cycle pulse: frame_sync arrived with a partial frame pending.

## Operation
- Registers: shadow[0..31], wr_idx (5 b), state, output bank, EN, sync_err.
- State FILL: sample_ready = 1.
  - On a transfer, shadow[wr_idx] <= sample_in and wr_idx increments.
  - If frame_sync is high on the transfer, the sample is written to shadow[0] and wr_idx <= 1.
  - In that frame_sync case, if wr_idx != 0 the partial frame is discarded and sync_err pulses.
  - frame_sync with wr_idx == 0 is legal and silent.
- Frame completion: a transfer at wr_idx == 31 without frame_sync.
  - If fft_ready = 1 in that cycle: output bank <= shadow[0..30] plus sample_in as out_31, EN <= 1, wr_idx <= 0, stay in FILL.
  - If fft_ready = 0: shadow[31] <= sample_in, go to HOLD.
- State HOLD: sample_ready = 0; frame_sync and sample_valid are ignored.
  - When fft_ready = 1: output bank <= shadow, EN <= 1, wr_idx <= 0, go to FILL.
- Output bank changes only on a frame transfer and otherwise holds its last frame indefinitely.
- No arithmetic; samples pass bit-exact. wr_idx wraps 31 -> 0 only through completion.

## Timing
- Reset (async assert; synchronous deassert handled by the reset synchroniser upstream):
  - out_0..out_31 = 0, EN = 0, sync_err = 0, wr_idx = 0, state = FILL.
  - sample_ready = 1 from the first cycle after reset.
- Reset mid-frame or in HOLD discards all shadow content. No EN is produced for the partial frame.
- sample_ready is combinational from state only, with no dependency on sample_valid. It does not depend on fft_ready in FILL.
- Latency: outputs and EN update on the clock edge that accepts sample 31, so back-to-back frames at full rate give EN every 32 cycles.
- EN is high for exactly one cycle per frame and never on two consecutive cycles.
- HOLD exit: EN on the edge where fft_ready is sampled high. sample_ready returns high in the following cycle.
- frame_sync on the sample-31 position restarts the frame instead of completing it, so no EN.

## Structure
- Shared package fft32_pkg:
  - N_POINTS = 32, IDX_W = 5.
  - typedef enum logic {FILL, HOLD} collector_state_t.
  - The sample type uses IN_ELEMENT_LENGTH.
- Single module. The shadow buffer is an unpacked array with an indexed write. No sub-module is warranted.

## Test plan
- Reset then 32 transfers of sample_in = k−16 (k = 0..31), fft_ready = 1, frame_sync on k = 0 -> EN once after the 32nd transfer edge, out_k = k−16, sync_err never.
- Two frames back-to-back with no gaps -> EN exactly 32 cycles apart; out holds frame 1 until frame 2's last edge.
- fft_ready = 0 during sample 31 -> HOLD, sample_ready = 0, out unchanged. fft_ready high 5 cycles later -> EN on that edge, correct frame, sample_ready = 1 next cycle.
- frame_sync on the 10th sample, value 0x7F -> sync_err pulse; the next 31 samples complete the frame with out_0 = 0x7F, and no EN for the 9 discarded samples.
- Random sample_valid gaps (~50%) with values 0x80/0x7F alternating -> frame content bit-exact and EN count = frames sent.
- rst_n low mid-frame (after 20 samples) and in HOLD -> all outputs 0 immediately; the next full 32 samples produce a clean frame.
